// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and segment table for the 7-segment display controller
package seg7_pkg;

   localparam int ON_BIT  = 31;
   localparam int BLZ_BIT = 24;
   localparam int DP_LSB  = 16;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Bits of the live register that actually exist for a given digit count
   function automatic logic [31:0] live_mask(input int num_digits);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < num_digits; i++) begin
         m[4*i +: 4]  = 4'hF;
         m[DP_LSB+i]  = 1'b1;
      end
      m[BLZ_BIT] = 1'b1;
      m[ON_BIT]  = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - CPU-side write/readback bus of the display peripheral
interface seg7_display_ctrl_if;

   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output we, output wdata, input rdata);
   modport slave  (input we, input wdata, output rdata);

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - memory-mapped multiplexed 7-segment display with tear-free frame commit
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FRAME_HZ   = 250,
   parameter int NUM_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   seg7_display_ctrl_if.slave    bus,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int DIV   = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [31:0] LIVE_MASK = live_mask(NUM_DIGITS);

   if (DIV < 2) begin : g_div_check
      $error("seg7_display_ctrl: refresh divider must be at least 2");
   end
   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_digit_check
      $error("seg7_display_ctrl: NUM_DIGITS must be in 2..8");
   end

   logic [31:0]           live;
   logic [31:0]           act;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic                  tick;
   logic                  last_idx;
   logic                  wrap;
   logic [3:0]            digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dp_mask;
   logic [3:0]            cur_digit;
   logic [6:0]            seg_raw;
   logic                  upper_zero;
   logic                  blank;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      assign digit[i] = act[4*i +: 4];
   end

   assign dp_mask   = act[DP_LSB +: NUM_DIGITS];
   assign tick      = (cnt == CNT_W'(DIV - 1));
   assign last_idx  = (idx == IDX_W'(NUM_DIGITS - 1));
   assign wrap      = tick && last_idx;
   assign cur_digit = digit[idx];

   hex_to_seg7 u_hex (
      .hex (cur_digit),
      .seg (seg_raw)
   );

   // A digit is a leading zero when it and every more-significant digit are zero
   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(idx) && digit[i] != 4'h0) begin
            upper_zero = 1'b0;
         end
      end
   end

   assign blank = act[BLZ_BIT] && (idx != '0) && upper_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         live <= '0;
         act  <= '0;
         cnt  <= '0;
         idx  <= '0;
         an   <= '1;
         seg  <= SEG_BLANK;
         dp   <= 1'b1;
      end else begin
         if (bus.we) begin
            live <= bus.wdata & LIVE_MASK;
         end
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            idx <= last_idx ? '0 : idx + 1'b1;
         end
         // Shadow copy only changes between frames so a frame never mixes two values
         if (wrap) begin
            act <= live;
         end
         if (act[ON_BIT]) begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= blank ? SEG_BLANK : seg_raw;
            dp  <= ~dp_mask[idx];
         end else begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end
      end
   end

   assign bus.rdata = live;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

   localparam int CLK_HZ   = 400;
   localparam int FRAME_HZ = 25;
   localparam int ND       = 4;
   localparam int DIV      = CLK_HZ / (FRAME_HZ * ND);
   localparam int FRAME    = DIV * ND;
   localparam logic [31:0] MASK = 32'h810F_FFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [6:0]    seg;
   logic          dp;
   logic [ND-1:0] an;

   seg7_display_ctrl_if bus ();

   seg7_display_ctrl #(
      .CLK_HZ     (CLK_HZ),
      .FRAME_HZ   (FRAME_HZ),
      .NUM_DIGITS (ND)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .seg (seg),
      .dp  (dp),
      .an  (an)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int passed = 0;
   int total  = 0;

   // Reference model: cycle count since reset gives scan position directly
   logic [31:0]   m_live = '0;
   logic [31:0]   m_act  = '0;
   int            m_k    = 0;
   logic [ND-1:0] e_an   = '1;
   logic [6:0]    e_seg  = 7'h7F;
   logic          e_dp   = 1'b1;

   task automatic model_outputs(input logic [31:0] a, input int i);
      logic [3:0] nib;
      nib = 4'(a[15:0] >> (4*i));
      if (!a[31]) begin
         e_an  = '1;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end else begin
         e_an  = ~(4'b0001 << i);
         e_seg = (a[24] && i > 0 && (a[15:0] >> (4*i)) == 16'h0) ? 7'h7F : seg_tab[nib];
         e_dp  = ~a[16+i];
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) begin
         m_live = '0;
         m_act  = '0;
         m_k    = 0;
         e_an   = '1;
         e_seg  = 7'h7F;
         e_dp   = 1'b1;
      end else begin
         model_outputs(m_act, (m_k / DIV) % ND);
         if (m_k % FRAME == FRAME - 1) m_act = m_live;
         if (bus.we) m_live = bus.wdata & MASK;
         m_k++;
      end
      #1;
   endtask

   task automatic write(input logic [31:0] d);
      bus.we    = 1'b1;
      bus.wdata = d;
      step();
      bus.we    = 1'b0;
   endtask

   task automatic test_reset();
      int lows;
      rst = 1'b1;
      bus.we = 1'b1;
      bus.wdata = 32'hFFFF_FFFF;
      step();
      step();
      rst = 1'b0;
      bus.we = 1'b0;
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
         $display("FAIL reset_pins: got an=%h seg=%h dp=%b, want an=f seg=7f dp=1", an, seg, dp);
      end else passed++;
      total++;
      if (bus.rdata !== 32'h0) begin
         $display("FAIL reset_rdata: got %h, want 00000000", bus.rdata);
      end else passed++;
      lows = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (an !== 4'hF) lows++;
      end
      total++;
      if (lows != 0) begin
         $display("FAIL reset_dark: got %0d cycles with an anode low, want 0", lows);
      end else passed++;
   endtask

   task automatic test_scan();
      logic [6:0] want;
      write(32'h8000_1234);
      total++;
      if (bus.rdata !== 32'h8000_1234) begin
         $display("FAIL scan_rdata: got %h, want 80001234", bus.rdata);
      end else passed++;
      for (int c = 0; c < 3*FRAME; c++) begin
         step();
         total++;
         if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
            $display("FAIL scan_model: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b", an, seg, dp, e_an, e_seg, e_dp);
         end else passed++;
         if (c > FRAME) begin
            case (an)
               4'hE:    want = 7'h19;
               4'hD:    want = 7'h30;
               4'hB:    want = 7'h24;
               4'h7:    want = 7'h79;
               default: want = 7'hxx;
            endcase
            total++;
            if (seg !== want) begin
               $display("FAIL scan_1234: an=%h got seg=%h, want %h", an, seg, want);
            end else passed++;
         end
      end
   endtask

   task automatic test_blanking(input logic [31:0] d, input logic [6:0] s0, input logic [6:0] s1);
      logic [6:0] want;
      write(d);
      for (int c = 0; c < 3*FRAME; c++) begin
         step();
         total++;
         if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
            $display("FAIL blank_model: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b", an, seg, dp, e_an, e_seg, e_dp);
         end else passed++;
         if (c > FRAME) begin
            case (an)
               4'hE:    want = s0;
               4'hD:    want = s1;
               4'hB:    want = 7'h7F;
               4'h7:    want = 7'h7F;
               default: want = 7'hxx;
            endcase
            total++;
            if (seg !== want) begin
               $display("FAIL blank_digits: data=%h an=%h got seg=%h, want %h", d, an, seg, want);
            end else passed++;
         end
      end
   endtask

   task automatic test_dp();
      logic [6:0] want;
      write(32'h800F_ABCD);
      for (int c = 0; c < 3*FRAME; c++) begin
         step();
         if (c > FRAME) begin
            case (an)
               4'hE:    want = 7'h21;
               4'hD:    want = 7'h46;
               4'hB:    want = 7'h03;
               4'h7:    want = 7'h08;
               default: want = 7'hxx;
            endcase
            total++;
            if (seg !== want || dp !== 1'b0) begin
               $display("FAIL dp_abcd: an=%h got seg=%h dp=%b, want seg=%h dp=0", an, seg, dp, want);
            end else passed++;
         end
      end
   endtask

   task automatic test_back_to_back_wrap();
      int n;
      logic [6:0] want;
      write(32'h8000_1234);
      repeat (2*FRAME) step();
      n = 0;
      while (m_k % FRAME != FRAME - 1 && n < FRAME) begin
         step();
         n++;
      end
      total++;
      if (m_k % FRAME != FRAME - 1) begin
         $display("FAIL wrap_align: got phase %0d, want %0d", m_k % FRAME, FRAME - 1);
      end else passed++;
      write(32'h8000_FFFF);
      for (int c = 0; c < FRAME; c++) begin
         step();
         case (an)
            4'hE:    want = 7'h19;
            4'hD:    want = 7'h30;
            4'hB:    want = 7'h24;
            4'h7:    want = 7'h79;
            default: want = 7'hxx;
         endcase
         total++;
         if (seg !== want) begin
            $display("FAIL wrap_old_frame: an=%h got seg=%h, want %h", an, seg, want);
         end else passed++;
      end
      for (int c = 0; c < FRAME; c++) begin
         step();
         total++;
         if (seg !== 7'h0E || an === 4'hF) begin
            $display("FAIL wrap_new_frame: an=%h got seg=%h, want seg=0e with an anode low", an, seg);
         end else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while ((m_k / DIV) % ND != 2 && n < FRAME) begin
         step();
         n++;
      end
      rst = 1'b1;
      bus.we = 1'b1;
      bus.wdata = 32'h8000_8888;
      step();
      rst = 1'b0;
      bus.we = 1'b0;
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || bus.rdata !== 32'h0) begin
         $display("FAIL midreset: got an=%h seg=%h dp=%b rdata=%h, want an=f seg=7f dp=1 rdata=0", an, seg, dp, bus.rdata);
      end else passed++;
      write(32'h8000_0001);
      for (int c = 0; c < 2*FRAME; c++) begin
         step();
         total++;
         if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
            $display("FAIL midreset_model: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b", an, seg, dp, e_an, e_seg, e_dp);
         end else passed++;
         if (m_k <= FRAME) begin
            total++;
            if (an !== 4'hF) begin
               $display("FAIL midreset_dark: cycle %0d got an=%h, want f", m_k, an);
            end else passed++;
         end else if (m_k == FRAME + 1) begin
            total++;
            if (an !== 4'hE || seg !== 7'h79) begin
               $display("FAIL midreset_first: got an=%h seg=%h, want an=e seg=79", an, seg);
            end else passed++;
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      for (int c = 0; c < 600; c++) begin
         rst    = ($urandom_range(0, 149) == 0);
         bus.we = ($urandom_range(0, 9) == 0);
         d      = $urandom;
         if ($urandom_range(0, 3) != 0) d[31] = 1'b1;
         if ($urandom_range(0, 1) == 0) d[15:0] = d[15:0] & 16'h00FF;
         bus.wdata = d;
         step();
         total++;
         if ({an, seg, dp} !== {e_an, e_seg, e_dp} || bus.rdata !== m_live) begin
            $display("FAIL random: got an=%h seg=%h dp=%b rdata=%h, want an=%h seg=%h dp=%b rdata=%h",
                     an, seg, dp, bus.rdata, e_an, e_seg, e_dp, m_live);
         end else passed++;
      end
      rst    = 1'b0;
      bus.we = 1'b0;
   endtask

   initial begin
      bus.we    = 1'b0;
      bus.wdata = '0;
      test_reset();
      test_scan();
      test_blanking(32'h8100_0050, 7'h40, 7'h12);
      test_blanking(32'h8100_0000, 7'h40, 7'h7F);
      test_dp();
      test_back_to_back_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
